fsk_frame_rx: RTL and testbench

- Framed binary-FSK receiver and word deserializer for the serial link.
- Samples a 1-bit square-wave FSK line on the receiver sample clock.
- Decides one bit per fixed window by counting rising edges (mark tone = 1, space tone = 0).
- Hunts for a sync pattern, then deserializes the following WORD_W bits into a parallel word with a one-cycle valid pulse for the downstream Hamming decoder.

---
 rtl/fsk_pkg.sv | 19 +
 rtl/fsk_bit_slicer.sv | 64 ++++++
 rtl/fsk_frame_rx.sv | 96 +++++++++
 tb/tb_fsk_frame_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared constants and FSM state for the FSK serial link.
// Used by both the receiver and the modulator side.
package fsk_pkg;
  localparam int SAMPLES_PER_BIT = 16;
  localparam int MARK_EDGES = 4;
  localparam int SPACE_EDGES = 2;
  localparam int WORD_W = 12;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 8'hA5;
  localparam int THRESH = (MARK_EDGES + SPACE_EDGES + 1) / 2;
  localparam int WIN_W = $clog2(SAMPLES_PER_BIT);
  localparam int CNT_W = $clog2(SAMPLES_PER_BIT + 1);
  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic {
    HUNT,
    DATA
  } state_t;
endpackage

// File: rtl/fsk_bit_slicer.sv
// FSK bit slicer: sync, edge count per window, bit decision.
// Ports: clk, reset (async low), fsk_in -> bit_val, bit_stb, total (FSK_RX_AMBIG_EN).
module fsk_bit_slicer
  import fsk_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             fsk_in,
`ifdef FSK_RX_AMBIG_EN
  output logic [CNT_W-1:0] total,
`endif
  output logic             bit_val,
  output logic             bit_stb
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(SAMPLES_PER_BIT - 1);

  logic             s1, s2, s3;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sum;
  logic             edge_hit;
  logic             last;

  assign edge_hit = s2 & ~s3;
  assign last = (win == WIN_LAST);
  // count including this cycle's edge, saturating
  assign sum = (edge_hit && cnt != CNT_MAX)
             ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      win     <= '0;
      cnt     <= '0;
      bit_val <= 1'b0;
      bit_stb <= 1'b0;
`ifdef FSK_RX_AMBIG_EN
      total   <= '0;
`endif
    end else begin
      s1      <= fsk_in;
      s2      <= s1;
      s3      <= s2;
      bit_stb <= 1'b0;
      if (last) begin
        win     <= '0;
        cnt     <= '0;
        bit_val <= (sum >= THR);
        bit_stb <= 1'b1;
`ifdef FSK_RX_AMBIG_EN
        total   <= sum;
`endif
      end else begin
        win <= win + WIN_W'(1);
        cnt <= sum;
      end
    end
  end
endmodule

// File: rtl/fsk_frame_rx.sv
// Framed FSK receiver: sync hunt and word deserializer.
// Ports: clk, reset, fsk_in -> dataout, valid, locked, bit_val, bit_stb, ambig_cnt (FSK_RX_AMBIG_EN).
module fsk_frame_rx
  import fsk_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fsk_in,
  output logic [WORD_W-1:0] dataout,
  output logic              valid,
  output logic              locked,
  output logic              bit_val,
`ifdef FSK_RX_AMBIG_EN
  output logic [7:0]        ambig_cnt,
`endif
  output logic              bit_stb
);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [SYNC_W-1:0] sync_sr;
  logic [WORD_W-1:0] data_sr;
  logic [IDX_W-1:0]  idx;
  logic [SYNC_W-1:0] sync_nxt;
  logic [WORD_W-1:0] data_nxt;

`ifdef FSK_RX_AMBIG_EN
  logic [CNT_W-1:0]  total;
`endif

  fsk_bit_slicer u_slicer (
    .clk     (clk),
    .reset   (reset),
    .fsk_in  (fsk_in),
`ifdef FSK_RX_AMBIG_EN
    .total   (total),
`endif
    .bit_val (bit_val),
    .bit_stb (bit_stb)
  );

  assign sync_nxt = {sync_sr[SYNC_W-2:0], bit_val};
  assign data_nxt = {data_sr[WORD_W-2:0], bit_val};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      sync_sr <= '0;
      data_sr <= '0;
      idx     <= '0;
      dataout <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (bit_stb) begin
        unique case (state)
          HUNT: begin
            sync_sr <= sync_nxt;
            if (sync_nxt == SYNC_PAT) begin
              state  <= DATA;
              idx    <= '0;
              locked <= 1'b1;
            end
          end
          DATA: begin
            data_sr <= data_nxt;
            idx     <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              dataout <= data_nxt;
              valid   <= 1'b1;
              state   <= HUNT;
              locked  <= 1'b0;
              sync_sr <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef FSK_RX_AMBIG_EN
  // windows that look like neither tone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ambig_cnt <= '0;
    end else if (bit_stb
              && total != CNT_W'(MARK_EDGES)
              && total != CNT_W'(SPACE_EDGES)
              && ambig_cnt != 8'hFF) begin
      ambig_cnt <= ambig_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fsk_frame_rx.sv
// Randomized self-checking bench for fsk_frame_rx.
// Frame-level reference model; build with FSK_RX_AMBIG_EN for ambig checks.
module tb_fsk_frame_rx;
  import fsk_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fsk_in = 1'b0;
  logic [WORD_W-1:0] dataout;
  logic              valid, locked, bit_val, bit_stb;
`ifdef FSK_RX_AMBIG_EN
  logic [7:0]        ambig_cnt;
`endif

  fsk_frame_rx dut (
    .clk       (clk),
    .reset     (reset),
    .fsk_in    (fsk_in),
    .dataout   (dataout),
    .valid     (valid),
    .locked    (locked),
    .bit_val   (bit_val),
`ifdef FSK_RX_AMBIG_EN
    .ambig_cnt (ambig_cnt),
`endif
    .bit_stb   (bit_stb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // reference model state
  bit bq[$];
  int nq[$];
  bit hist[$];
  bit dq[$];
  bit m_lock;
  int m_amb;
  bit pend;
  bit e_valid;
  logic [WORD_W-1:0] e_word;
  int n_stb = 0;
  int n_vexp = 0;
  int n_vgot = 0;

  task automatic model_reset();
    hist.delete();
    repeat (SYNC_W) hist.push_back(1'b0);
    dq.delete();
    bq.delete();
    nq.delete();
    m_lock = 0;
    m_amb = 0;
    pend = 0;
  endtask

  task automatic model_step(input bit b, input int n);
    logic [SYNC_W-1:0] pat;
    bit match;
    int w;
    pat = SYNC_PAT;
    e_valid = 0;
    if (n != MARK_EDGES && n != SPACE_EDGES && m_amb < 255)
      m_amb++;
    if (!m_lock) begin
      hist.push_back(b);
      void'(hist.pop_front());
      match = 1;
      for (int i = 0; i < SYNC_W; i++)
        if (hist[i] != pat[SYNC_W-1-i]) match = 0;
      if (match) begin
        m_lock = 1;
        dq.delete();
      end
    end else begin
      dq.push_back(b);
      if (dq.size() == WORD_W) begin
        w = 0;
        foreach (dq[i]) w = w * 2 + int'(dq[i]);
        e_word = w[WORD_W-1:0];
        e_valid = 1;
        n_vexp++;
        m_lock = 0;
        hist.delete();
        repeat (SYNC_W) hist.push_back(1'b0);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    bit b;
    int n;
    if (reset) begin
      if (valid) n_vgot++;
      if (pend) begin
        pend = 0;
        check("locked", locked, m_lock);
        check("valid", valid, e_valid);
        if (e_valid) check("dataout", dataout, e_word);
`ifdef FSK_RX_AMBIG_EN
        check("ambig_cnt", ambig_cnt, m_amb);
`endif
      end else if (valid) begin
        check("valid_spurious", valid, 1'b0);
      end
      if (bit_stb) begin
        n_stb++;
        if (bq.size() == 0) begin
          check("stb_extra", bit_stb, 1'b0);
        end else begin
          b = bq.pop_front();
          n = nq.pop_front();
          check("bit_val", bit_val, b);
          model_step(b, n);
          pend = 1;
        end
      end
    end
  end

  // one bit window carrying n rising edges
  task automatic send_win(input int n);
    bq.push_back(n >= THRESH);
    nq.push_back(n);
    for (int j = 0; j < SAMPLES_PER_BIT; j++) begin
      fsk_in = (j % 3 == 1) && (j / 3 < n);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] v,
                           input int w,
                           input bit nom);
    int n;
    for (int i = w - 1; i >= 0; i--) begin
      if (nom) n = v[i] ? MARK_EDGES : SPACE_EDGES;
      else if (v[i]) n = int'($urandom_range(3, 4));
      else n = int'($urandom_range(0, 2));
      send_win(n);
    end
  endtask

  task automatic frame(input logic [WORD_W-1:0] word,
                       input bit nom);
    send_bits(32'(SYNC_PAT), SYNC_W, nom);
    send_bits(32'(word), WORD_W, nom);
  endtask

  task automatic settle();
    fsk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fsk_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataout", dataout, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_bit_val", bit_val, 0);
    check("rst_bit_stb", bit_stb, 0);
`ifdef FSK_RX_AMBIG_EN
    check("rst_ambig", ambig_cnt, 0);
`endif
    reset = 1'b1;
  endtask

  int v0, s0;
  logic [WORD_W-1:0] rw;

  initial begin
    @(posedge clk);
    #1;
    // idle line
    do_reset();
    s0 = n_stb;
    v0 = n_vgot;
    repeat (20) send_win(0);
    settle();
    check("idle_stb", n_stb - s0, 20);
    check("idle_valid", n_vgot - v0, 0);
    check("idle_locked", locked, 0);

    // single nominal frame
    do_reset();
    v0 = n_vgot;
    frame(12'hB3C, 1);
    settle();
    check("b3c_cnt", n_vgot - v0, 1);
    check("b3c_word", dataout, 12'hB3C);
    check("b3c_unlock", locked, 0);

    // back-to-back frames
    do_reset();
    v0 = n_vgot;
    frame(12'h001, 1);
    frame(12'hFFF, 1);
    settle();
    check("b2b_cnt", n_vgot - v0, 2);
    check("b2b_word", dataout, 12'hFFF);

    // sync found in a sliding prefix
    do_reset();
    v0 = n_vgot;
    send_bits(32'hA52B3, 20, 1);
    settle();
    check("slide_cnt", n_vgot - v0, 1);
    check("slide_word", dataout, 12'h2B3);

    // abort mid-word then a clean frame
    do_reset();
    send_bits(32'(SYNC_PAT), SYNC_W, 1);
    send_bits(32'h2D, 6, 1);
    settle();
    check("abort_lock", locked, 1);
    do_reset();
    v0 = n_vgot;
    frame(12'h5A5, 1);
    settle();
    check("abort_cnt", n_vgot - v0, 1);
    check("abort_word", dataout, 12'h5A5);

    // random frames with noisy edge counts
    do_reset();
    for (int f = 0; f < 8; f++) begin
      send_bits($urandom, int'($urandom_range(0, 6)), 0);
      rw = WORD_W'($urandom);
      frame(rw, 0);
    end
    settle();

    // ambiguous windows
    do_reset();
    repeat (5) send_win(3);
    repeat (2) send_win(4);
    settle();
`ifdef FSK_RX_AMBIG_EN
    check("ambig_total", ambig_cnt, 5);
`endif

    check("valid_total", n_vgot, n_vexp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
